// File: rtl/mdu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl_pkg
// Shared CPU definitions used by the MDU issue controller and the multi-cycle
// multiply/divide unit:
//   oper_t  - operation encoding carried down the pipeline
//   is_mc() - classifies operations that need the multi-cycle unit
// -----------------------------------------------------------------------------
package mdu_issue_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_MFHI  = 5'd3,
    OP_MFLO  = 5'd4,
    OP_MTHI  = 5'd5,
    OP_MTLO  = 5'd6,
    OP_MADD  = 5'd7,
    OP_MADDU = 5'd8,
    OP_MSUB  = 5'd9,
    OP_MSUBU = 5'd10,
    OP_MUL   = 5'd11,
    OP_MULT  = 5'd12,
    OP_MULTU = 5'd13,
    OP_DIV   = 5'd14,
    OP_DIVU  = 5'd15
  } oper_t;

  // Operations that occupy the multi-cycle unit and stall the pipeline.
  function automatic logic is_mc(input oper_t op);
    logic mc;
    mc = 1'b0;
    case (op)
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
      OP_MUL, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: mc = 1'b1;
      default:                                   mc = 1'b0;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl
// Issue/commit controller in front of a multi-cycle multiply/divide unit.
// Owns the architectural HI/LO pair and the OP_MUL GPR result register.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               aborts any in-flight operation
//   req_valid/req_op    issue request and its operation
//   req_reg1/req_reg2   source operands
//   req_wdata           data for OP_MTHI / OP_MTLO
//   stall               holds the upstream pipeline
//   exe_op/exe_reg1/2   operation and operands driven to the unit
//   exe_hilo            current {HI,LO} driven to the unit
//   exe_flush           flush to the unit (flush or reset)
//   exe_ret             unit result {HI,LO}
//   exe_mult_word       unit low-word product (OP_MUL)
//   exe_busy            unit still computing
//   hilo                architectural {HI,LO}
//   mul_valid/mul_word  one-cycle OP_MUL writeback pulse and its data
//
// Handshake: a request is consumed on a rising edge where req_valid=1 and
// stall=0. A multi-cycle op raises stall in its own issue cycle and keeps it
// through RUN; upstream must hold its request until stall is low. Requests
// seen while RUN or DONE are dropped and get re-presented by upstream.
// -----------------------------------------------------------------------------
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter logic [63:0] HILO_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  input  oper_t       req_op,
  input  logic [31:0] req_reg1,
  input  logic [31:0] req_reg2,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output oper_t       exe_op,
  output logic [31:0] exe_reg1,
  output logic [31:0] exe_reg2,
  output logic [63:0] exe_hilo,
  output logic        exe_flush,
  input  logic [63:0] exe_ret,
  input  logic [31:0] exe_mult_word,
  input  logic        exe_busy,
  output logic [63:0] hilo,
  output logic        mul_valid,
  output logic [31:0] mul_word
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  oper_t       op_q, op_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] reg2_q, reg2_d;
  logic [63:0] hilo_q, hilo_d;
  logic [31:0] mul_word_q, mul_word_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    reg1_d     = reg1_q;
    reg2_d     = reg2_q;
    hilo_d     = hilo_q;
    mul_word_d = mul_word_q;
    exe_op     = OP_NOP;
    exe_reg1   = 32'd0;
    exe_reg2   = 32'd0;
    stall      = 1'b0;
    mul_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = req_valid && is_mc(req_op);
        // Flush suppresses both a new issue and an MTHI/MTLO write.
        if (req_valid && !flush) begin
          if (is_mc(req_op)) begin
            op_d    = req_op;
            reg1_d  = req_reg1;
            reg2_d  = req_reg2;
            state_d = S_RUN;
          end else if (req_op == OP_MTHI) begin
            hilo_d[63:32] = req_wdata;
          end else if (req_op == OP_MTLO) begin
            hilo_d[31:0] = req_wdata;
          end
        end
      end

      S_RUN: begin
        stall    = 1'b1;
        exe_op   = op_q;
        exe_reg1 = reg1_q;
        exe_reg2 = reg2_q;
        if (flush) begin
          state_d = S_IDLE;
        end else if (!exe_busy) begin
          if (op_q == OP_MUL) begin
            mul_word_d = exe_mult_word;
          end else begin
            hilo_d = exe_ret;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // op_q still names the op that just committed.
        mul_valid = (op_q == OP_MUL) && !flush;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs that would otherwise reflect pre-reset state are quiet in reset.
    if (rst) begin
      stall     = 1'b0;
      mul_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      reg1_q     <= 32'd0;
      reg2_q     <= 32'd0;
      hilo_q     <= HILO_RESET;
      mul_word_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      reg1_q     <= reg1_d;
      reg2_q     <= reg2_d;
      hilo_q     <= hilo_d;
      mul_word_q <= mul_word_d;
    end
  end

  assign exe_hilo  = hilo_q;
  assign hilo      = hilo_q;
  assign mul_word  = mul_word_q;
  assign exe_flush = flush || rst;

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; aborts any in-flight operation.
- req_valid  in  1  issue request present this cycle.
- req_op  in  oper_t  operation of the request.
- req_reg1, req_reg2  in  32 each  source operands.
- req_wdata  in  32  data for OP_MTHI/OP_MTLO.
- stall  out  1  holds upstream pipeline.
- exe_op  out  oper_t  operation to the multi-cycle unit.
- exe_reg1, exe_reg2  out  32 each  operands to the unit.
- exe_hilo  out  64  current {HI,LO} to the unit.
- exe_flush  out  1  flush to the unit.
- exe_ret  in  64  unit result {HI,LO}.
- exe_mult_word  in  32  unit low-word product.
- exe_busy  in  1  unit still computing.
- hilo  out  64  architectural {HI,LO}, for MFHI/MFLO.
- mul_valid  out  1  one-cycle pulse: mul_word valid for OP_MUL writeback.
- mul_word  out  32  OP_MUL GPR result.
REQ-002 SHALL have one parameter: HILO_RESET, default 64'h0, reset value of HI/LO.

Function
REQ-003 SHALL classify OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU as multi-cycle ops (mc).
REQ-004 SHALL implement states IDLE, RUN, DONE.
REQ-005 IDLE: exe_op = OP_NOP, exe_reg1/2 = 0; on req_valid && mc && !flush, latch op/reg1/reg2 and go to RUN.
REQ-006 IDLE: on req_valid && op==OP_MTHI, HI <= req_wdata; op==OP_MTLO, LO <= req_wdata; state stays IDLE; single-cycle, no stall.
REQ-007 RUN: drive latched op/reg1/reg2 unchanged every cycle; when exe_busy==0, commit and go to DONE.
REQ-008 Commit: OP_MUL writes mul_word <= exe_mult_word and leaves HI/LO unchanged; all other mc ops write {HI,LO} <= exe_ret.
REQ-009 DONE: exe_op = OP_NOP; mul_valid = 1 only if the committed op was OP_MUL; unconditionally return to IDLE next cycle.
REQ-010 stall = (IDLE && req_valid && mc) || RUN; stall = 0 in DONE.
REQ-011 Latency: issue-to-DONE = unit busy length + 1 cycle. MULT family: IDLE->RUN->RUN->DONE, 3 stall cycles total incl. the issue cycle. DIV family: 36 RUN cycles.
REQ-012 exe_hilo SHALL equal the HI/LO register; MADD/MSUB accumulate into the value held at issue; HI/LO SHALL not change while in RUN.
REQ-013 flush in any state: exe_flush = 1 same cycle, go to IDLE next edge, no HI/LO or mul_word write, mul_valid = 0; flush wins over a same-cycle commit or issue.
REQ-014 In RUN/DONE, requests (incl. MTHI/MTLO) SHALL be ignored; upstream re-presents them after stall drops.
REQ-015 Non-mc, non-MT ops SHALL be ignored with no state change.
REQ-016 exe_flush = flush || rst.

Reset
REQ-017 On rst: state IDLE, {HI,LO} = HILO_RESET, mul_word = 0, mul_valid = 0, latched op = OP_NOP, operands = 0, stall = 0.
REQ-018 rst mid-RUN SHALL discard the operation with no commit; rst overrides flush and req_valid.

Structure
REQ-019 oper_t and the OP_* encodings SHALL come from the shared cpu package; the state enum SHALL stay local.
REQ-020 The mc-class decode SHALL be a package function shared with the multi-cycle unit; there are no sub-modules; the unit is instantiated by the parent.

Verification
REQ-021 MULTU 0xFFFFFFFF x 2 -> stall for 3 cycles, hilo = 64'h1_FFFFFFFE, mul_valid = 0.
REQ-022 MTLO 5, MTHI 1, then MADD 3 x -2 -> hilo = 64'h0000_0000_FFFF_FFFF (0x1_00000005 - 6).
REQ-023 MUL -7 x 6 -> mul_valid pulses once with mul_word = 0xFFFFFFD6; hilo unchanged.
REQ-024 DIV -7 / 2 -> after 36 RUN cycles, hilo = {32'hFFFFFFFF, 32'hFFFFFFFD}; stall drops in DONE.
REQ-025 Flush at DIV RUN cycle 10 -> IDLE next cycle, hilo unchanged, exe_op = OP_NOP, a following MULTU 3 x 3 gives hilo = 9.
REQ-026 Held MTHI during DIV RUN -> ignored; HI reflects the DIV remainder, then the MTHI applies once stall drops.
